// File: rtl/fifo_rr_ctrl_if.sv
// Bundle of source, FIFO and output-stream signals around fifo_rr_ctrl.
// master = the controller side, slave = sources, FIFO and consumer.
interface fifo_rr_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int N_SRC  = 4
);
   logic [N_SRC-1:0]        src_valid;
   logic [N_SRC*DATA_W-1:0] src_data;
   logic [N_SRC-1:0]        src_ready;
   logic                    fifo_wr;
   logic [DATA_W-1:0]       fifo_wr_data;
   logic                    fifo_full;
   logic                    fifo_rd;
   logic [DATA_W-1:0]       fifo_rd_data;
   logic                    fifo_empty;
   logic                    out_valid;
   logic [DATA_W-1:0]       out_data;
   logic                    out_ready;

   modport master (
      input  src_valid, src_data, fifo_full, fifo_rd_data, fifo_empty, out_ready,
      output src_ready, fifo_wr, fifo_wr_data, fifo_rd, out_valid, out_data
   );

   modport slave (
      output src_valid, src_data, fifo_full, fifo_rd_data, fifo_empty, out_ready,
      input  src_ready, fifo_wr, fifo_wr_data, fifo_rd, out_valid, out_data
   );
endinterface

// File: rtl/fifo_rr_ctrl.sv
// Round-robin write arbiter into a shared FIFO plus a two-entry read
// sequencer turning the FIFO's 1-cycle read latency into a valid/ready stream.
module fifo_rr_ctrl #(
   parameter int DATA_W = 8,
   parameter int N_SRC  = 4,
   parameter int SRC_W  = $clog2(N_SRC)
) (
   input  logic          clk,
   input  logic          rst,
   fifo_rr_ctrl_if.master bus
);
   logic [SRC_W-1:0]  r_rr_ptr;
   logic [SRC_W-1:0]  w_grant;
   logic [SRC_W-1:0]  w_ptr_nxt;
   logic              w_found;
   logic              w_wr;
   int unsigned       w_idx;

   logic [1:0]        r_occ;
   logic              r_inflight;
   logic              r_head;
   logic              r_tail;
   logic [DATA_W-1:0] r_buf [2];
   logic              w_pop;
   logic              w_rd;
   logic [2:0]        w_level;

   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_idx   = 0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         w_idx = (k + 32'(r_rr_ptr)) % 32'(N_SRC);
         if (!w_found && bus.src_valid[SRC_W'(w_idx)]) begin
            w_found = 1'b1;
            w_grant = SRC_W'(w_idx);
         end
      end
      // Gating with rst keeps the strobes low while the FIFO itself is held in reset.
      w_wr      = w_found && !bus.fifo_full && !rst;
      w_ptr_nxt = (w_grant == SRC_W'(N_SRC - 1)) ? '0 : w_grant + SRC_W'(1);
   end

   assign bus.src_ready    = w_wr ? (N_SRC'(1) << w_grant) : '0;
   assign bus.fifo_wr      = w_wr;
   assign bus.fifo_wr_data = w_wr ? bus.src_data[w_grant*DATA_W +: DATA_W] : '0;

   // Occupancy after this cycle's in-flight push and pop; a read is only
   // issued if its data is guaranteed a buffer slot.
   assign w_pop   = (r_occ != 2'd0) && bus.out_ready;
   assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_rd    = !rst && !bus.fifo_empty && (w_level < 3'd2);

   assign bus.fifo_rd   = w_rd;
   assign bus.out_valid = (r_occ != 2'd0);
   assign bus.out_data  = r_buf[r_head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr   <= '0;
         r_occ      <= '0;
         r_inflight <= 1'b0;
         r_head     <= 1'b0;
         r_tail     <= 1'b0;
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
      end else begin
         r_inflight <= w_rd;
         r_occ      <= w_level[1:0];
         if (w_wr) r_rr_ptr <= w_ptr_nxt;
         if (r_inflight) begin
            r_buf[r_tail] <= bus.fifo_rd_data;
            r_tail        <= ~r_tail;
         end
         if (w_pop) r_head <= ~r_head;
      end
   end
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Directed bench for fifo_rr_ctrl with a depth-4 synchronous FIFO beside it.
module tb_fifo_rr_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_rr_ctrl_if #(.DATA_W(8), .N_SRC(4)) bus ();

   fifo_rr_ctrl #(.DATA_W(8), .N_SRC(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Shared FIFO: registered count, data_out held between reads.
   logic [7:0] f_mem [4];
   logic [1:0] f_wp, f_rp;
   logic [2:0] f_cnt;
   logic [7:0] f_dout;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         f_wp <= '0; f_rp <= '0; f_cnt <= '0; f_dout <= '0;
      end else begin
         if (bus.fifo_wr) begin
            f_mem[f_wp] <= bus.fifo_wr_data;
            f_wp        <= f_wp + 2'd1;
         end
         if (bus.fifo_rd) begin
            f_dout <= f_mem[f_rp];
            f_rp   <= f_rp + 2'd1;
         end
         f_cnt <= f_cnt + 3'(bus.fifo_wr) - 3'(bus.fifo_rd);
      end
   end

   assign bus.fifo_empty   = (f_cnt == 3'd0);
   assign bus.fifo_full    = (f_cnt == 3'd4);
   assign bus.fifo_rd_data = f_dout;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         n_cyc    = 0;
   logic [7:0] got_q [$];
   int         got_cyc [$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;
   logic [3:0] last_acc   = '0;
   int         wcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample at negedge, return at posedge+1 ready for new inputs.
   task automatic step();
      @(negedge clk);
      n_cyc++;
      chk("rd_while_empty", 32'(bus.fifo_rd && bus.fifo_empty), 0);
      if (bus.fifo_full) chk("wr_while_full", {bus.fifo_wr, bus.src_ready}, 0);
      if (prev_stall) begin
         chk("stall_valid", 32'(bus.out_valid), 1);
         chk("stall_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
         got_q.push_back(bus.out_data);
         got_cyc.push_back(n_cyc);
      end
      last_acc   = bus.src_valid & bus.src_ready;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_q.delete();
      got_cyc.delete();
      prev_stall = 1'b0;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.src_valid = '0;
      bus.src_data  = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_mon();
   endtask

   initial begin
      // Reset state with all sources requesting
      bus.src_valid = 4'hF;
      bus.src_data  = 32'h13121110;
      bus.out_ready = 1'b1;
      #2;
      chk("rst_src_ready", 32'(bus.src_ready), 0);
      chk("rst_fifo_wr", 32'(bus.fifo_wr), 0);
      chk("rst_fifo_rd", 32'(bus.fifo_rd), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      do_reset();

      // Single word: 3-cycle latency, 1 cycle of out_valid
      bus.src_valid = 4'b0001;
      bus.src_data  = 32'h000000A5;
      bus.out_ready = 1'b1;
      #1;
      chk("single_wr", 32'(bus.fifo_wr), 1);
      chk("single_ready", 32'(bus.src_ready), 32'h1);
      chk("single_wr_data", 32'(bus.fifo_wr_data), 32'hA5);
      chk("single_valid_t0", 32'(bus.out_valid), 0);
      step();
      bus.src_valid = '0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk($sformatf("single_valid_t%0d", k), 32'(bus.out_valid), (k == 3) ? 1 : 0);
         if (k == 3) chk("single_data", 32'(bus.out_data), 32'hA5);
         step();
      end

      // Fairness: all sources valid, grants rotate 0,1,2,3
      do_reset();
      bus.src_data  = 32'h13121110;
      bus.src_valid = 4'hF;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk($sformatf("fair_grant_%0d", k), 32'(bus.src_ready), 32'(1 << (k % 4)));
         step();
      end
      bus.src_valid = '0;
      repeat (8) step();
      chk("fair_count", got_q.size(), 12);
      for (int i = 0; i < got_q.size(); i++) begin
         chk($sformatf("fair_data_%0d", i), 32'(got_q[i]), 32'h10 + 32'(i % 4));
         chk($sformatf("fair_gap_%0d", i), got_cyc[i] - got_cyc[0], i);
      end

      // Full: out_ready low, source 0 streams; 4 words in FIFO + 2 in buffer
      do_reset();
      wcnt = 0;
      for (int k = 0; k < 12; k++) begin
         bus.src_valid = 4'b0001;
         bus.src_data  = 32'(wcnt[7:0]);
         step();
         if (last_acc[0]) wcnt++;
      end
      chk("full_accepted", wcnt, 6);
      chk("full_flag", 32'(bus.fifo_full), 1);
      chk("full_head", 32'(bus.out_data), 0);
      bus.src_valid = '0;
      bus.out_ready = 1'b1;
      repeat (12) step();
      chk("full_drain_count", got_q.size(), 6);
      for (int i = 0; i < got_q.size(); i++)
         chk($sformatf("full_drain_%0d", i), 32'(got_q[i]), i);

      // Backpressure: 64 words, random out_ready
      do_reset();
      wcnt = 0;
      for (int c = 0; c < 800 && got_q.size() < 64; c++) begin
         bus.src_valid = (wcnt < 64) ? 4'b0001 : 4'b0000;
         bus.src_data  = 32'(wcnt[7:0]);
         bus.out_ready = 1'($urandom_range(0, 1));
         step();
         if (last_acc[0]) wcnt++;
      end
      chk("bp_count", got_q.size(), 64);
      for (int i = 0; i < got_q.size(); i++)
         chk($sformatf("bp_data_%0d", i), 32'(got_q[i]), i);

      // Mid-stream reset while streaming at full rate
      do_reset();
      bus.src_data  = 32'h33323130;
      bus.src_valid = 4'hF;
      bus.out_ready = 1'b1;
      repeat (6) step();
      chk("mid_pre_valid", 32'(bus.out_valid), 1);
      chk("mid_pre_rd", 32'(bus.fifo_rd), 1);
      rst = 1'b1;
      #1;
      chk("mid_out_valid", 32'(bus.out_valid), 0);
      chk("mid_fifo_wr", 32'(bus.fifo_wr), 0);
      chk("mid_fifo_rd", 32'(bus.fifo_rd), 0);
      chk("mid_src_ready", 32'(bus.src_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_mon();
      bus.src_data = 32'h23222120;
      #1;
      chk("mid_grant0", 32'(bus.src_ready), 32'h1);
      chk("mid_wr_data", 32'(bus.fifo_wr_data), 32'h20);
      step();
      bus.src_valid = '0;
      repeat (8) step();
      chk("mid_out_count", got_q.size(), 1);
      if (got_q.size() > 0) chk("mid_first_out", 32'(got_q[0]), 32'h20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
